// File: rtl/sha256_pkg.sv
// Shared SHA-256 constants, round functions, FSM state type and counter sizing
// for sha256_stream_core and sha256_round.
package sha256_pkg;

    typedef enum logic [1:0] {IDLE, ROUND, ADD, DONE} state_t;

    localparam logic [31:0] K [0:63] = '{
        32'h428a2f98, 32'h71374491, 32'hb5c0fbcf, 32'he9b5dba5, 32'h3956c25b, 32'h59f111f1, 32'h923f82a4, 32'hab1c5ed5,
        32'hd807aa98, 32'h12835b01, 32'h243185be, 32'h550c7dc3, 32'h72be5d74, 32'h80deb1fe, 32'h9bdc06a7, 32'hc19bf174,
        32'he49b69c1, 32'hefbe4786, 32'h0fc19dc6, 32'h240ca1cc, 32'h2de92c6f, 32'h4a7484aa, 32'h5cb0a9dc, 32'h76f988da,
        32'h983e5152, 32'ha831c66d, 32'hb00327c8, 32'hbf597fc7, 32'hc6e00bf3, 32'hd5a79147, 32'h06ca6351, 32'h14292967,
        32'h27b70a85, 32'h2e1b2138, 32'h4d2c6dfc, 32'h53380d13, 32'h650a7354, 32'h766a0abb, 32'h81c2c92e, 32'h92722c85,
        32'ha2bfe8a1, 32'ha81a664b, 32'hc24b8b70, 32'hc76c51a3, 32'hd192e819, 32'hd6990624, 32'hf40e3585, 32'h106aa070,
        32'h19a4c116, 32'h1e376c08, 32'h2748774c, 32'h34b0bcb5, 32'h391c0cb3, 32'h4ed8aa4a, 32'h5b9cca4f, 32'h682e6ff3,
        32'h748f82ee, 32'h78a5636f, 32'h84c87814, 32'h8cc70208, 32'h90befffa, 32'ha4506ceb, 32'hbef9a3f7, 32'hc67178f2
    };

    localparam logic [255:0] IV = {
        32'h6a09e667, 32'hbb67ae85, 32'h3c6ef372, 32'ha54ff53a,
        32'h510e527f, 32'h9b05688c, 32'h1f83d9ab, 32'h5be0cd19
    };

    function automatic logic [31:0] rotr(input logic [31:0] x, input int unsigned n);
        return (x >> n) | (x << (32 - n));
    endfunction

    function automatic logic [31:0] ch(input logic [31:0] e, input logic [31:0] f, input logic [31:0] g);
        return (e & f) ^ (~e & g);
    endfunction

    function automatic logic [31:0] maj(input logic [31:0] a, input logic [31:0] b, input logic [31:0] c);
        return (a & b) ^ (a & c) ^ (b & c);
    endfunction

    function automatic logic [31:0] sum0(input logic [31:0] x);
        return rotr(x, 2) ^ rotr(x, 13) ^ rotr(x, 22);
    endfunction

    function automatic logic [31:0] sum1(input logic [31:0] x);
        return rotr(x, 6) ^ rotr(x, 11) ^ rotr(x, 25);
    endfunction

    function automatic logic [31:0] sigma0(input logic [31:0] x);
        return rotr(x, 7) ^ rotr(x, 18) ^ (x >> 3);
    endfunction

    function automatic logic [31:0] sigma1(input logic [31:0] x);
        return rotr(x, 17) ^ rotr(x, 19) ^ (x >> 10);
    endfunction

    // Bits needed to count 64/rpc round cycles (minimum 1).
    function automatic int unsigned cnt_width(input int unsigned rpc);
        int unsigned cycles;
        int unsigned w;
        cycles = 64 / rpc;
        w = 1;
        while ((32'd1 << w) < cycles) w++;
        return w;
    endfunction

endpackage

// File: rtl/sha256_round.sv
// One combinational SHA-256 compression round: working variables a..h in,
// next a..h out, given the round constant Kt and schedule word Wt.
module sha256_round
    import sha256_pkg::*;
(
    input  logic [31:0] a,
    input  logic [31:0] b,
    input  logic [31:0] c,
    input  logic [31:0] d,
    input  logic [31:0] e,
    input  logic [31:0] f,
    input  logic [31:0] g,
    input  logic [31:0] h,
    input  logic [31:0] k_t,
    input  logic [31:0] w_t,
    output logic [31:0] a_n,
    output logic [31:0] b_n,
    output logic [31:0] c_n,
    output logic [31:0] d_n,
    output logic [31:0] e_n,
    output logic [31:0] f_n,
    output logic [31:0] g_n,
    output logic [31:0] h_n
);

    logic [31:0] t1;
    logic [31:0] t2;

    always_comb begin
        t1  = h + sum1(e) + ch(e, f, g) + k_t + w_t;
        t2  = sum0(a) + maj(a, b, c);
        a_n = t1 + t2;
        b_n = a;
        c_n = b;
        d_n = c;
        e_n = d + t1;
        f_n = e;
        g_n = f;
        h_n = g;
    end

endmodule

// File: rtl/sha256_stream_core.sv
// Iterative multi-block SHA-256 engine with valid/ready block input and digest output.
// Optional macro SHA256_MIDSTATE_IN_EN adds midstate/use_mid ports to seed the chain.
module sha256_stream_core
    import sha256_pkg::*;
#(
    parameter int unsigned ROUNDS_PER_CYCLE = 1,
    parameter bit          BSWAP_OUT        = 1'b0
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         blk_valid,
    output logic         blk_ready,
    input  logic [511:0] blk_data,
    input  logic         blk_first,
    input  logic         blk_last,
    output logic         digest_valid,
    input  logic         digest_ready,
    output logic [255:0] digest,
`ifdef SHA256_MIDSTATE_IN_EN
    input  logic [255:0] midstate,
    input  logic         use_mid,
`endif
    output logic         busy
);

    localparam int unsigned NCYC = 64 / ROUNDS_PER_CYCLE;
    localparam int unsigned CW   = cnt_width(ROUNDS_PER_CYCLE);
    localparam logic [CW-1:0] LAST_CNT = CW'(NCYC - 1);

    if (!(ROUNDS_PER_CYCLE == 1 || ROUNDS_PER_CYCLE == 2 ||
          ROUNDS_PER_CYCLE == 4 || ROUNDS_PER_CYCLE == 8)) begin : g_bad_rpc
        $error("sha256_stream_core: ROUNDS_PER_CYCLE must be 1, 2, 4 or 8");
    end

    state_t        state, state_nx;
    logic [CW-1:0] rnd_cnt;
    logic          add_ph;
    logic          last_q;
    logic          armed;
    logic          xfer;
    logic [31:0]   h_q  [8];
    logic [31:0]   wv_q [8];
    logic [31:0]   w_q  [16];
    logic [31:0]   w_ext [16 + ROUNDS_PER_CYCLE];
    logic [31:0]   st   [ROUNDS_PER_CYCLE + 1][8];
    logic [255:0]  h_pack;
    logic [255:0]  chain_init;
    logic [255:0]  dig_fmt;
    logic [255:0]  digest_q;

    assign blk_ready    = (state == IDLE) && armed;
    assign xfer         = blk_valid && blk_ready;
    assign digest_valid = (state == DONE);
    assign busy         = (state != IDLE);
    assign digest       = digest_q;

    for (genvar i = 0; i < 8; i++) begin : g_st0
        assign st[0][i] = wv_q[i];
    end

    for (genvar r = 0; r < ROUNDS_PER_CYCLE; r++) begin : g_rnd
        logic [5:0] kidx;
        assign kidx = 6'(rnd_cnt * 6'(ROUNDS_PER_CYCLE)) + 6'(r);
        sha256_round u_round (
            .a   (st[r][0]), .b(st[r][1]), .c(st[r][2]), .d(st[r][3]),
            .e   (st[r][4]), .f(st[r][5]), .g(st[r][6]), .h(st[r][7]),
            .k_t (K[kidx]),
            .w_t (w_q[r]),
            .a_n (st[r+1][0]), .b_n(st[r+1][1]), .c_n(st[r+1][2]), .d_n(st[r+1][3]),
            .e_n (st[r+1][4]), .f_n(st[r+1][5]), .g_n(st[r+1][6]), .h_n(st[r+1][7])
        );
    end

    // Window is extended by R words and then slid forward by R.
    always_comb begin
        for (int unsigned j = 0; j < 16; j++) w_ext[j] = w_q[j];
        for (int unsigned j = 16; j < 16 + ROUNDS_PER_CYCLE; j++)
            w_ext[j] = sigma1(w_ext[j-2]) + w_ext[j-7] + sigma0(w_ext[j-15]) + w_ext[j-16];
    end

    always_comb begin
        h_pack = '0;
        for (int unsigned i = 0; i < 8; i++) h_pack[255-32*i -: 32] = h_q[i];
        dig_fmt = h_pack;
        if (BSWAP_OUT)
            for (int unsigned b = 0; b < 32; b++) dig_fmt[8*b +: 8] = h_pack[255-8*b -: 8];
    end

    always_comb begin
        chain_init = h_pack;
        if (blk_first) chain_init = IV;
`ifdef SHA256_MIDSTATE_IN_EN
        if (blk_first && use_mid) chain_init = midstate;
`endif
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) state <= IDLE;
        else     state <= state_nx;
    end

    always_comb begin
        state_nx = state;
        case (state)
            IDLE:    if (xfer) state_nx = ROUND;
            ROUND:   if (rnd_cnt == LAST_CNT) state_nx = ADD;
            ADD:     if (add_ph) state_nx = last_q ? DONE : IDLE;
            DONE:    if (digest_ready) state_nx = IDLE;
            default: state_nx = IDLE;
        endcase
    end

    // ADD spans two cycles: chain update, then digest capture from the
    // registered chain, keeping the 32-bit adders off the digest register path.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            rnd_cnt  <= '0;
            add_ph   <= 1'b0;
            last_q   <= 1'b0;
            armed    <= 1'b0;
            digest_q <= '0;
            for (int unsigned i = 0; i < 8; i++) begin
                h_q[i]  <= IV[255-32*i -: 32];
                wv_q[i] <= '0;
            end
            for (int unsigned j = 0; j < 16; j++) w_q[j] <= '0;
        end else begin
            armed <= 1'b1;
            case (state)
                IDLE: if (xfer) begin
                    for (int unsigned i = 0; i < 8; i++) begin
                        h_q[i]  <= chain_init[255-32*i -: 32];
                        wv_q[i] <= chain_init[255-32*i -: 32];
                    end
                    for (int unsigned j = 0; j < 16; j++) w_q[j] <= blk_data[511-32*j -: 32];
                    last_q  <= blk_last;
                    rnd_cnt <= '0;
                    add_ph  <= 1'b0;
                end
                ROUND: begin
                    for (int unsigned i = 0; i < 8; i++) wv_q[i] <= st[ROUNDS_PER_CYCLE][i];
                    for (int unsigned j = 0; j < 16; j++) w_q[j] <= w_ext[j + ROUNDS_PER_CYCLE];
                    rnd_cnt <= (rnd_cnt == LAST_CNT) ? '0 : rnd_cnt + CW'(1);
                end
                ADD: begin
                    if (!add_ph) begin
                        for (int unsigned i = 0; i < 8; i++) h_q[i] <= h_q[i] + wv_q[i];
                        add_ph <= 1'b1;
                    end else begin
                        add_ph <= 1'b0;
                        if (last_q) digest_q <= dig_fmt;
                    end
                end
                default: ;
            endcase
        end
    end

endmodule
